crtc_shadow_regs: RTL and testbench
===================================

Name: crtc_shadow_regs

Overview:
- Wishbone responder giving the MCU (via the SPI1 Wishbone initiator) read and write access to a shadow copy of the 6545 CRTC register file.
- Snoops the CPU-side CRTC bus (address/register-select writes at the 1 MHz strobe) so the shadow always mirrors what the PET program last wrote.
- Sits behind the wb_mux as another peripheral, selected by address decode in the top level; plugs into the video block's currently unused Wishbone peripheral ports.

Parameters:
REG_COUNT, 18, number of implemented CRTC registers (R0..R17)
WB_ADDR_WIDTH, 20, width of wb_addr_i
DATA_WIDTH, 8, data bus width

Ports:
wb_clock_i  input  1  64 MHz system clock; all logic on rising edge
wb_reset_i  input  1  synchronous, active-high reset
wb_addr_i  input  WB_ADDR_WIDTH  Wishbone address; only [4:0] decoded
wb_data_i  input  DATA_WIDTH  Wishbone write data
wb_data_o  output  DATA_WIDTH  Wishbone read data, valid with ack
wb_we_i  input  1  Wishbone write enable
wb_cycle_i  input  1  Wishbone cycle
wb_strobe_i  input  1  Wishbone strobe
wb_sel_i  input  1  peripheral select from top-level decode
wb_stall_o  output  1  Wishbone stall
wb_ack_o  output  1  Wishbone ack
crtc_clk_en_i  input  1  1-cycle CPU write strobe (1 MHz)
crtc_cs_i  input  1  CPU address is in CRTC range
crtc_rs_i  input  1  0 = address register, 1 = data register
crtc_we_i  input  1  CPU write (1) / read (0)
crtc_data_i  input  DATA_WIDTH  CPU -> CRTC data

Behaviour:
- Reset: shadow[0..REG_COUNT-1]=0, addr_reg=0, dirty=0, wb_ack_o=0, wb_stall_o=0, wb_data_o=0. Reset mid-transaction discards the pending ack.
- CPU snoop: event = crtc_clk_en_i & crtc_cs_i & crtc_we_i.
  - rs=0: addr_reg <= crtc_data_i[4:0].
  - rs=1 and addr_reg<REG_COUNT: shadow[addr_reg] <= crtc_data_i, dirty <= 1.
  - rs=1 and addr_reg>=REG_COUNT: ignored; dirty unchanged.
  - CPU reads (crtc_we_i=0) have no effect.
- WB accept: cycle & strobe & sel & !stall.
- WB map by idx=wb_addr_i[4:0]:
  - idx<REG_COUNT: shadow[idx], R/W.
  - 0x1E: {7'b0,dirty}. A read returns dirty, then clears it; writes are ignored.
  - 0x1F: {3'b0,addr_reg}, R/W.
  - Other idx: read 0, write ignored.
- WB timing: one outstanding transaction.
  - Cycle T accept: address/data/we captured; wb_stall_o=1 at T+1.
  - T+1: read data registered into wb_data_o; write committed.
  - T+2: wb_ack_o=1 for exactly one cycle; wb_stall_o returns 0 the same cycle. Back-to-back accept is possible at T+2.
  - Read latency: 2 cycles accept-to-ack.
- wb_data_o holds its last value when not acking. It is 0 on write acks.
- Abort: if wb_cycle_i drops before ack, the pending transaction is cancelled, no ack is issued, stall clears next cycle, and a write not yet committed is dropped.
- Collisions:
  - CPU data write and WB write to the same shadow register in the same commit cycle: CPU value wins.
  - CPU addr write and WB write to 0x1F in the same cycle: CPU wins.
  - CPU data write setting dirty in the same cycle a WB read of 0x1E clears it: dirty ends 1, and the read returns the pre-event value.
- WB writes to shadow never set dirty.
- No combinational path from WB inputs to outputs.

Test Plan:
- Reset, then WB read idx 0..17, 0x1E, 0x1F -> each acks 2 cycles after accept with data 0x00; stall high exactly one cycle per transaction.
- CPU strobe rs=0 data 0x0C, then rs=1 data 0x10 -> WB read idx 12 = 0x10, idx 0x1F = 0x0C, idx 0x1E = 0x01; second read of 0x1E = 0x00.
- CPU writes addr 0x14, then data 0xAA -> no shadow changes, dirty stays 0; WB read 0x1F = 0x14, idx 20 reads 0x00.
- WB write idx 5 = 0x3C in the same cycle the commit coincides with a CPU write of 0x77 to R5 -> readback 0x77; WB-only write of 0x3C to R5 reads back 0x3C with dirty 0.
- WB read accepted, wb_cycle_i dropped at T+1 -> no ack, stall low by T+2; next read completes normally. Repeat with wb_reset_i at T+1 -> no ack, all registers 0.
- Back-to-back: strobe held high for 4 reads of idx 0..3 after preloading 0x11,0x22,0x33,0x44 -> acks at T+2, T+4, T+6, T+8 with data in order; stall pattern 0,1,0,1….

Source files
------------

// File: rtl/crtc_shadow_regs.sv
// Shadow copy of the 6545 CRTC register file: snooped from CPU writes, and
// readable/writable over a single-outstanding Wishbone responder port.
module crtc_shadow_regs #(
    parameter int REG_COUNT     = 18,
    parameter int WB_ADDR_WIDTH = 20,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     wb_clock_i,
    input  logic                     wb_reset_i,
    input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [DATA_WIDTH-1:0]    wb_data_i,
    output logic [DATA_WIDTH-1:0]    wb_data_o,
    input  logic                     wb_we_i,
    input  logic                     wb_cycle_i,
    input  logic                     wb_strobe_i,
    input  logic                     wb_sel_i,
    output logic                     wb_stall_o,
    output logic                     wb_ack_o,
    input  logic                     crtc_clk_en_i,
    input  logic                     crtc_cs_i,
    input  logic                     crtc_rs_i,
    input  logic                     crtc_we_i,
    input  logic [DATA_WIDTH-1:0]    crtc_data_i
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [4:0] DIRTY_IDX = 5'h1E;
    localparam logic [4:0] ADDR_IDX  = 5'h1F;

    state_t                state;
    logic [DATA_WIDTH-1:0] shadow [REG_COUNT];
    logic [4:0]            addr_reg;
    logic                  dirty;
    logic [4:0]            req_idx;
    logic                  req_we;
    logic [DATA_WIDTH-1:0] req_data;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  accept;
    logic                  cpu_wr;
    logic                  unused_addr_bits;

    assign accept           = wb_cycle_i & wb_strobe_i & wb_sel_i & ~wb_stall_o;
    assign cpu_wr           = crtc_clk_en_i & crtc_cs_i & crtc_we_i;
    assign unused_addr_bits = ^wb_addr_i[WB_ADDR_WIDTH-1:5];

    // Read mux works from the captured index, so WB inputs never reach outputs.
    always_comb begin
        rd_val = '0;
        if (int'(req_idx) < REG_COUNT)
            rd_val = shadow[req_idx];
        else if (req_idx == DIRTY_IDX)
            rd_val = DATA_WIDTH'(dirty);
        else if (req_idx == ADDR_IDX)
            rd_val = DATA_WIDTH'(addr_reg);
    end

    always_ff @(posedge wb_clock_i) begin
        if (wb_reset_i) begin
            state      <= IDLE;
            wb_stall_o <= 1'b0;
            wb_ack_o   <= 1'b0;
            wb_data_o  <= '0;
            addr_reg   <= '0;
            dirty      <= 1'b0;
            req_idx    <= '0;
            req_we     <= 1'b0;
            req_data   <= '0;
            shadow     <= '{default: '0};
        end else begin
            wb_ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_idx    <= wb_addr_i[4:0];
                        req_we     <= wb_we_i;
                        req_data   <= wb_data_i;
                        state      <= BUSY;
                        wb_stall_o <= 1'b1;
                    end
                end
                BUSY: begin
                    state      <= IDLE;
                    wb_stall_o <= 1'b0;
                    if (wb_cycle_i) begin
                        wb_ack_o <= 1'b1;
                        if (req_we) begin
                            wb_data_o <= '0;
                            if (int'(req_idx) < REG_COUNT)
                                shadow[req_idx] <= req_data;
                            else if (req_idx == ADDR_IDX)
                                addr_reg <= req_data[4:0];
                        end else begin
                            wb_data_o <= rd_val;
                            if (req_idx == DIRTY_IDX)
                                dirty <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // CPU snoop comes last so it wins any same-cycle collision with a WB commit.
            if (cpu_wr) begin
                if (!crtc_rs_i) begin
                    addr_reg <= crtc_data_i[4:0];
                end else if (int'(addr_reg) < REG_COUNT) begin
                    shadow[addr_reg] <= crtc_data_i;
                    dirty            <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_crtc_shadow_regs.sv
// Self-checking bench for crtc_shadow_regs: vector table plus scoreboard of
// expected read data and ack cycle, with hand sequences for collisions/aborts.
module tb_crtc_shadow_regs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] wb_addr = '0;
    logic [7:0]  wb_wdata = '0;
    logic [7:0]  wb_rdata;
    logic        wb_we = 1'b0;
    logic        wb_cycle = 1'b0;
    logic        wb_strobe = 1'b0;
    logic        wb_sel = 1'b0;
    logic        wb_stall;
    logic        wb_ack;
    logic        crtc_clk_en = 1'b0;
    logic        crtc_cs = 1'b0;
    logic        crtc_rs = 1'b0;
    logic        crtc_we = 1'b0;
    logic [7:0]  crtc_data = '0;

    crtc_shadow_regs #(.REG_COUNT(18), .WB_ADDR_WIDTH(20), .DATA_WIDTH(8)) dut (
        .wb_clock_i(clk), .wb_reset_i(rst), .wb_addr_i(wb_addr), .wb_data_i(wb_wdata),
        .wb_data_o(wb_rdata), .wb_we_i(wb_we), .wb_cycle_i(wb_cycle),
        .wb_strobe_i(wb_strobe), .wb_sel_i(wb_sel), .wb_stall_o(wb_stall),
        .wb_ack_o(wb_ack), .crtc_clk_en_i(crtc_clk_en), .crtc_cs_i(crtc_cs),
        .crtc_rs_i(crtc_rs), .crtc_we_i(crtc_we), .crtc_data_i(crtc_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         due;
        string      name;
    } exp_t;

    typedef struct {
        logic       we;
        logic [4:0] idx;
        logic [7:0] wd;
        logic [7:0] exp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[33];
    int   cnt = 0;
    int   checks = 0;
    int   passes = 0;

    always @(posedge clk) cnt <= cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard: every ack pops one expectation and checks data and ack cycle.
    always @(negedge clk) begin
        if (wb_ack) begin
            if (sb.size() == 0) begin
                check("spurious_ack", 32'(wb_ack), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_data"}, 32'(wb_rdata), 32'(e.data));
                check({e.name, "_ack_cycle"}, 32'(cnt), 32'(e.due));
            end
        end
    end

    task automatic cpu_write(input logic rs, input logic [7:0] d);
        crtc_clk_en = 1'b1; crtc_cs = 1'b1; crtc_we = 1'b1; crtc_rs = rs; crtc_data = d;
        @(posedge clk); #1;
        crtc_clk_en = 1'b0; crtc_cs = 1'b0;
    endtask

    // Single WB transaction; optionally fires a CPU write onto the commit edge.
    task automatic wb_txn(input logic we, input logic [4:0] idx, input logic [7:0] wd,
                          input logic [7:0] exp, input string name,
                          input logic hit = 1'b0, input logic hit_rs = 1'b0,
                          input logic [7:0] hit_d = 8'h00);
        wb_addr = {15'b0, idx}; wb_wdata = wd; wb_we = we;
        wb_cycle = 1'b1; wb_strobe = 1'b1; wb_sel = 1'b1;
        @(posedge clk); #1;
        sb.push_back('{exp, cnt + 1, name});
        check({name, "_stall_hi"}, 32'(wb_stall), 32'd1);
        wb_strobe = 1'b0;
        if (hit) begin
            crtc_clk_en = 1'b1; crtc_cs = 1'b1; crtc_we = 1'b1; crtc_rs = hit_rs; crtc_data = hit_d;
        end
        @(posedge clk); #1;
        crtc_clk_en = 1'b0; crtc_cs = 1'b0;
        check({name, "_stall_lo"}, 32'(wb_stall), 32'd0);
        @(posedge clk); #1;
        wb_cycle = 1'b0; wb_sel = 1'b0; wb_we = 1'b0;
        check({name, "_acked"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 20; i++)
            vecs[i] = '{1'b0, (i < 18) ? 5'(i) : ((i == 18) ? 5'h1E : 5'h1F), 8'h00, 8'h00};
        vecs[20] = '{1'b1, 5'd0,  8'h11, 8'h00};
        vecs[21] = '{1'b1, 5'd1,  8'h22, 8'h00};
        vecs[22] = '{1'b1, 5'd2,  8'h33, 8'h00};
        vecs[23] = '{1'b1, 5'd3,  8'h44, 8'h00};
        vecs[24] = '{1'b0, 5'h1E, 8'h00, 8'h00};
        vecs[25] = '{1'b1, 5'h1F, 8'h07, 8'h00};
        vecs[26] = '{1'b0, 5'h1F, 8'h00, 8'h07};
        vecs[27] = '{1'b1, 5'h1E, 8'hFF, 8'h00};
        vecs[28] = '{1'b0, 5'h1E, 8'h00, 8'h00};
        vecs[29] = '{1'b1, 5'd25, 8'h55, 8'h00};
        vecs[30] = '{1'b0, 5'd25, 8'h00, 8'h00};
        vecs[31] = '{1'b1, 5'd17, 8'hA5, 8'h00};
        vecs[32] = '{1'b0, 5'd17, 8'h00, 8'hA5};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_ack", 32'(wb_ack), 32'd0);
        check("reset_stall", 32'(wb_stall), 32'd0);
        check("reset_data", 32'(wb_rdata), 32'd0);

        for (int i = 0; i < 20; i++)
            wb_txn(vecs[i].we, vecs[i].idx, vecs[i].wd, vecs[i].exp, $sformatf("rst_rd%0d", i));

        cpu_write(1'b0, 8'h0C);
        cpu_write(1'b1, 8'h10);
        wb_txn(1'b0, 5'd12,  8'h00, 8'h10, "snoop_r12");
        wb_txn(1'b0, 5'h1F,  8'h00, 8'h0C, "snoop_addr");
        wb_txn(1'b0, 5'h1E,  8'h00, 8'h01, "snoop_dirty1");
        wb_txn(1'b0, 5'h1E,  8'h00, 8'h00, "snoop_dirty2");

        cpu_write(1'b0, 8'h14);
        cpu_write(1'b1, 8'hAA);
        wb_txn(1'b0, 5'h1E,  8'h00, 8'h00, "oob_dirty");
        wb_txn(1'b0, 5'h1F,  8'h00, 8'h14, "oob_addr");
        wb_txn(1'b0, 5'd20,  8'h00, 8'h00, "oob_r20");
        wb_txn(1'b0, 5'd12,  8'h00, 8'h10, "oob_r12");

        cpu_write(1'b0, 8'h05);
        wb_txn(1'b1, 5'd5,   8'h3C, 8'h00, "coll_wr5", 1'b1, 1'b1, 8'h77);
        wb_txn(1'b0, 5'd5,   8'h00, 8'h77, "coll_rd5");
        wb_txn(1'b0, 5'h1E,  8'h00, 8'h01, "coll_dirty");
        wb_txn(1'b1, 5'd5,   8'h3C, 8'h00, "wbonly_wr5");
        wb_txn(1'b0, 5'd5,   8'h00, 8'h3C, "wbonly_rd5");
        wb_txn(1'b0, 5'h1E,  8'h00, 8'h00, "wbonly_dirty");

        for (int i = 20; i < 33; i++)
            wb_txn(vecs[i].we, vecs[i].idx, vecs[i].wd, vecs[i].exp, $sformatf("vec%0d", i));

        // addr_reg is 7 here: dirty read collides with a CPU data write to R7
        wb_txn(1'b0, 5'h1E,  8'h00, 8'h00, "dcoll_rd", 1'b1, 1'b1, 8'h5A);
        wb_txn(1'b0, 5'h1E,  8'h00, 8'h01, "dcoll_after");
        wb_txn(1'b0, 5'd7,   8'h00, 8'h5A, "dcoll_r7");
        wb_txn(1'b1, 5'h1F,  8'h09, 8'h00, "acoll_wr", 1'b1, 1'b0, 8'h04);
        wb_txn(1'b0, 5'h1F,  8'h00, 8'h04, "acoll_rd");

        // Back-to-back reads of R0..R3 with strobe held high
        wb_addr = '0; wb_we = 1'b0; wb_cycle = 1'b1; wb_strobe = 1'b1; wb_sel = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [7:0] e;
            e = 8'(8'h11 * (k + 1));
            @(posedge clk); #1;
            sb.push_back('{e, cnt + 1, $sformatf("b2b%0d", k)});
            check($sformatf("b2b%0d_stall_hi", k), 32'(wb_stall), 32'd1);
            if (k < 3) wb_addr = 20'(k + 1);
            else wb_strobe = 1'b0;
            @(posedge clk); #1;
            check($sformatf("b2b%0d_stall_lo", k), 32'(wb_stall), 32'd0);
        end
        @(posedge clk); #1;
        wb_cycle = 1'b0; wb_sel = 1'b0;
        check("b2b_acked", 32'(sb.size()), 32'd0);
        sb.delete();

        // Abort a write before commit; it must not land
        wb_addr = 20'd2; wb_wdata = 8'h99; wb_we = 1'b1;
        wb_cycle = 1'b1; wb_strobe = 1'b1; wb_sel = 1'b1;
        @(posedge clk); #1;
        check("abort_stall_hi", 32'(wb_stall), 32'd1);
        wb_cycle = 1'b0; wb_strobe = 1'b0; wb_sel = 1'b0; wb_we = 1'b0;
        @(posedge clk); #1;
        check("abort_no_ack", 32'(wb_ack), 32'd0);
        check("abort_stall_lo", 32'(wb_stall), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        wb_txn(1'b0, 5'd2, 8'h00, 8'h33, "abort_r2");
        wb_txn(1'b0, 5'd1, 8'h00, 8'h22, "abort_r1");

        // Reset lands on the commit edge of a pending read
        wb_addr = 20'd3; wb_we = 1'b0; wb_cycle = 1'b1; wb_strobe = 1'b1; wb_sel = 1'b1;
        @(posedge clk); #1;
        wb_strobe = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; wb_cycle = 1'b0; wb_sel = 1'b0;
        check("rstab_ack", 32'(wb_ack), 32'd0);
        check("rstab_stall", 32'(wb_stall), 32'd0);
        check("rstab_data", 32'(wb_rdata), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        wb_txn(1'b0, 5'd0,  8'h00, 8'h00, "rstab_r0");
        wb_txn(1'b0, 5'd3,  8'h00, 8'h00, "rstab_r3");
        wb_txn(1'b0, 5'd17, 8'h00, 8'h00, "rstab_r17");
        wb_txn(1'b0, 5'h1E, 8'h00, 8'h00, "rstab_dirty");
        wb_txn(1'b0, 5'h1F, 8'h00, 8'h00, "rstab_addr");

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
